booth_multiplier: RTL



---
 rtl/booth_multiplier.sv | 124 ++++++++++++
 1 files changed

// File: rtl/booth_multiplier.sv
// Sequential radix-4 Booth multiplier with per-operation signed/unsigned mode.
// Retires two multiplier bits per cycle; op_done rises WIDTH/2+2 edges after the accept edge.

module booth_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               signed_mode,
  input  logic               op_start,
  input  logic               op_clear,
  output logic               op_busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 6;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [EW-1:0]        m_q;
  logic [EW-1:0]        m_d;
  logic                 mprev_q;
  logic signed [EW-1:0] b_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 busy_q;
  logic                 done_q;

  logic signed [AW-1:0] b_ext_s;
  logic signed [AW-1:0] pp_s;
  logic signed [AW-1:0] acc_sum_s;

  function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {{2{sgn & v[WIDTH-1]}}, v};
  endfunction

  // Partial products are added WIDTH+2 bits up so that N two-bit shifts land the product at bit 0.
  always_comb begin
    b_ext_s = {{(AW-EW){b_q[EW-1]}}, b_q};
    pp_s    = '0;
    case ({m_q[1:0], mprev_q})
      3'b001, 3'b010: pp_s = b_ext_s;
      3'b011:         pp_s = b_ext_s <<< 1;
      3'b100:         pp_s = -(b_ext_s <<< 1);
      3'b101, 3'b110: pp_s = -b_ext_s;
      default:        pp_s = '0;
    endcase
    acc_sum_s = acc_q + (pp_s <<< (WIDTH + 2));
    acc_d     = acc_sum_s >>> 2;
    m_d       = {2'b00, m_q[EW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      mprev_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            m_q     <= extend(multiplier, signed_mode);
            b_q     <= extend(multiplicand, signed_mode);
            mprev_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The edge after the last iteration publishes the product.
          if (cnt_q == LAST_ITER) begin
            result_q <= acc_q[2*WIDTH-1:0];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            acc_q   <= acc_d;
            m_q     <= m_d;
            mprev_q <= m_q[1];
            cnt_q   <= cnt_q + CW'(1);
            busy_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op_busy = busy_q;
  assign op_done = done_q;
  assign result  = result_q;

endmodule
